// File: rtl/rv32i_types.sv
// Shared RV32I core types: fetch-stage FSM encoding, IF/ID payload, NOP encoding.
package rv32i_types;

  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

endpackage

// File: rtl/if_stage_ifid_register.sv
// IF/ID pipeline register plus a one-entry pending buffer for responses that arrive while decode is stalled.
// Pending occupancy is implied by the fetch FSM being in HOLD, so only the payload is stored here.
module ifid_register
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        park_i,
  input  logic        promote_i,
  input  logic        drop_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] fetch_instr_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o
);

  logic  valid_q, valid_d;
  ifid_t ifid_q, ifid_d;
  ifid_t pend_q, pend_d;

  // Controls are mutually exclusive in practice; the order is a safety net.
  always_comb begin
    valid_d = valid_q;
    ifid_d  = ifid_q;
    pend_d  = pend_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ifid_d  = '{pc: fetch_pc_i, instr: fetch_instr_i};
    end else if (park_i) begin
      pend_d  = '{pc: fetch_pc_i, instr: fetch_instr_i};
    end else if (promote_i) begin
      valid_d = 1'b1;
      ifid_d  = pend_q;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ifid_q  <= '{pc: 32'h0, instr: NOP_INSTR};
      pend_q  <= '{pc: 32'h0, instr: NOP_INSTR};
    end else begin
      valid_q <= valid_d;
      ifid_q  <= ifid_d;
      pend_q  <= pend_d;
    end
  end

  assign ifid_valid_o = valid_q;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_instr_o = ifid_q.instr;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the imem port, feeds decode via IF/ID.
// Stalls park one response in a pending buffer; EX redirects flush and discard in-flight fetches.
module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instruction
);

  if_state_t   state_q;
  logic [31:0] pc_q;
  logic [31:0] disc_addr_q;  // address still owed to memory after a redirect

  logic accept, redirect_act, in_fetch_resp;
  logic flush, load, park, promote, drop;

  assign accept        = !ifid_valid || !stall_id;
  assign redirect_act  = redirect_valid && (state_q != START);
  assign in_fetch_resp = !redirect_act && (state_q == FETCH) && imem_resp;

  assign flush   = redirect_act;
  assign load    = in_fetch_resp && accept;
  assign park    = in_fetch_resp && !accept;
  assign promote = !redirect_act && (state_q == HOLD) && !stall_id;
  assign drop    = !redirect_act && (state_q == FETCH) && !imem_resp && accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= START;
      pc_q        <= RESET_PC;
      disc_addr_q <= RESET_PC;
    end else if (redirect_act) begin
      pc_q <= redirect_target & 32'hFFFF_FFFC;
      if (state_q == FETCH && !imem_resp) begin
        state_q     <= DISCARD;
        disc_addr_q <= pc_q;
      end else if (state_q == DISCARD && !imem_resp) begin
        state_q <= DISCARD;
      end else begin
        state_q <= FETCH;
      end
    end else begin
      case (state_q)
        START:   state_q <= FETCH;
        FETCH: begin
          if (imem_resp) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= accept ? FETCH : HOLD;
          end
        end
        HOLD:    if (!stall_id) state_q <= FETCH;
        DISCARD: if (imem_resp) state_q <= FETCH;
        default: state_q <= START;
      endcase
    end
  end

  assign imem_read    = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_address = ((state_q == DISCARD) ? disc_addr_q : pc_q) & 32'hFFFF_FFFC;

  ifid_register u_ifid (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .load_i        (load),
    .park_i        (park),
    .promote_i     (promote),
    .drop_i        (drop),
    .fetch_pc_i    (pc_q),
    .fetch_instr_i (imem_rdata),
    .ifid_valid_o  (ifid_valid),
    .ifid_pc_o     (ifid_pc),
    .ifid_instr_o  (ifid_instruction)
  );

endmodule
